// File: rtl/sat_counter_table_if.sv
// Prediction/training port bundle for the 2-bit saturating counter table.
// The branch predictor drives the master side; the table is the slave.
interface sat_counter_table_if #(
  parameter int unsigned INDEX = 12
);
  logic             stall;
  logic [INDEX-1:0] pred_sel;
  logic [INDEX-1:0] update_sel;
  logic             update;
  logic             up_down;
  logic             pred;

  modport master (
    output stall, pred_sel, update_sel, update, up_down,
    input  pred
  );

  modport slave (
    input  stall, pred_sel, update_sel, update, up_down,
    output pred
  );
endinterface

// File: rtl/sat_counter_table.sv
// Pattern history table of 2-bit saturating counters: one combinational
// prediction read port and one clocked training port.
module sat_counter_table #(
  parameter int unsigned WIDTH = 4096,
  parameter int unsigned INDEX = 12
) (
  input  logic               clk,
  input  logic               reset,
  sat_counter_table_if.slave bus
);

  logic [1:0] cnt_q [WIDTH];
  logic [1:0] cnt_d;
  logic       wr_en;

  // Only the addressed entry is ever recomputed; all others hold implicitly.
  always_comb begin
    wr_en = bus.update && !bus.stall;
    cnt_d = cnt_q[bus.update_sel];
    if (bus.up_down) begin
      if (cnt_d != 2'b11) cnt_d = cnt_d + 2'd1;
    end else begin
      if (cnt_d != 2'b00) cnt_d = cnt_d - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= 2'b01;
    end else if (wr_en) begin
      cnt_q[bus.update_sel] <= cnt_d;
    end
  end

  // Read is not bypassed: a same-cycle update becomes visible after the edge.
  assign bus.pred = cnt_q[bus.pred_sel][1];

endmodule

// File: tb/tb_sat_counter_table.sv
// Self-checking bench for sat_counter_table: directed test-plan steps
// followed by randomized training checked against an array reference model.
module tb_sat_counter_table;
  localparam int unsigned INDEX = 12;
  localparam int unsigned WIDTH = 4096;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   model [WIDTH];

  sat_counter_table_if #(.INDEX(INDEX)) bus ();

  sat_counter_table #(.WIDTH(WIDTH), .INDEX(INDEX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Apply the rules to the model using the values driven now, then clock.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) model[i] = 1;
    end else if (!bus.stall && bus.update) begin
      if (bus.up_down) model[bus.update_sel] = (model[bus.update_sel] + 1 > 3) ? 3 : model[bus.update_sel] + 1;
      else             model[bus.update_sel] = (model[bus.update_sel] - 1 < 0) ? 0 : model[bus.update_sel] - 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [INDEX-1:0] sel, input logic exp);
    bus.pred_sel = sel;
    #1;
    total++;
    assert (bus.pred === exp) else begin
      bad++;
      $error("FAIL %s sel=%0h: pred=%b expected=%b", tag, sel, bus.pred, exp);
    end
  endtask

  task automatic check_model(input string tag, input logic [INDEX-1:0] sel);
    check(tag, sel, model[sel] >= 2);
  endtask

  task automatic train(input logic [INDEX-1:0] sel, input logic dir);
    bus.update_sel = sel;
    bus.pred_sel   = sel;
    bus.update     = 1'b1;
    bus.up_down    = dir;
    bus.stall      = 1'b0;
    tick();
    bus.update     = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.pred_sel = '0;
    bus.update_sel = '0;
    bus.update = 1'b0;
    bus.up_down = 1'b0;
    @(negedge clk);
    tick();
    reset = 1'b0;

    check("reset_0", 12'h000, 1'b0);
    check("reset_1", 12'h001, 1'b0);
    check("reset_2047", 12'h7FF, 1'b0);
    check("reset_4095", 12'hFFF, 1'b0);

    // Train toward taken, saturate, then back down.
    train(12'h0A5, 1'b1); check("tk_e1", 12'h0A5, 1'b1);
    train(12'h0A5, 1'b1); check("tk_e2", 12'h0A5, 1'b1);
    train(12'h0A5, 1'b1); check("tk_e3", 12'h0A5, 1'b1);
    train(12'h0A5, 1'b0); check("tk_dec1", 12'h0A5, 1'b1);
    train(12'h0A5, 1'b0); check("tk_dec2", 12'h0A5, 1'b0);

    // Floor saturation: three decrements then two increments.
    for (int i = 0; i < 3; i++) begin
      train(12'hFFF, 1'b0); check("floor_dec", 12'hFFF, 1'b0);
    end
    train(12'hFFF, 1'b1); check("floor_inc1", 12'hFFF, 1'b0);
    train(12'hFFF, 1'b1); check("floor_inc2", 12'hFFF, 1'b1);

    // Stall and update gating.
    bus.update_sel = 12'h123; bus.up_down = 1'b1;
    bus.stall = 1'b1; bus.update = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); check("stall", 12'h123, 1'b0); end
    bus.stall = 1'b0; bus.update = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); check("no_update", 12'h123, 1'b0); end
    train(12'h123, 1'b1); check("after_gate", 12'h123, 1'b1);

    // Isolation and same-cycle read (no bypass).
    bus.update_sel = 12'h010; bus.update = 1'b1; bus.up_down = 1'b1;
    check("same_cycle", 12'h010, 1'b0);
    tick();
    bus.update = 1'b0;
    train(12'h010, 1'b1);
    check("iso_self", 12'h010, 1'b1);
    check("iso_up", 12'h011, 1'b0);
    check("iso_down", 12'h00F, 1'b0);

    // Reset overrides a coincident update.
    train(12'h200, 1'b1); train(12'h200, 1'b1);
    check("mid_pre", 12'h200, 1'b1);
    reset = 1'b1; bus.update_sel = 12'h200; bus.update = 1'b1; bus.up_down = 1'b1;
    tick();
    reset = 1'b0; bus.update = 1'b0;
    check("mid_reset", 12'h200, 1'b0);
    check("mid_reset_other", 12'h0A5, 1'b0);
    train(12'h200, 1'b1); check("mid_reset_01", 12'h200, 1'b1);

    // Randomized training over a small window so entries saturate often.
    for (int n = 0; n < 600; n++) begin
      reset          = ($urandom_range(0, 59) == 0);
      bus.stall      = ($urandom_range(0, 7) == 0);
      bus.update     = $urandom_range(0, 1);
      bus.up_down    = ($urandom_range(0, 9) < 6);
      bus.update_sel = 12'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 12'h800 : 12'h000);
      check_model("rnd_pre", bus.update_sel);
      tick();
      reset = 1'b0;
      check_model("rnd_post", 12'($urandom_range(0, 15)));
    end
    for (int s = 0; s < 16; s++) check_model("rnd_sweep", 12'(s));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
